// File: rtl/mem_io_responder.sv
// mem_io_responder: services CPU loads/stores on off-chip SRAM or the UART.
// Returns read data with a one-cycle done pulse; busy while a request runs.
package mem_io_pkg;
  localparam logic [3:0] IO_NOP = 4'd0;
  localparam logic [3:0] IO_LW  = 4'd1;
  localparam logic [3:0] IO_LB  = 4'd2;
  localparam logic [3:0] IO_SW  = 4'd3;
  localparam logic [3:0] IO_SB  = 4'd4;
endpackage

module mem_io_responder
  import mem_io_pkg::*;
#(
  parameter int          SRAM_WAIT      = 2,
  parameter logic [31:0] UART_DATA_ADDR = 32'hBFD003F8,
  parameter logic [31:0] UART_STAT_ADDR = 32'hBFD003FC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  mem_mode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic [19:0] sram_addr,
  output logic [31:0] sram_wdata,
  output logic        sram_drive,
  input  logic [31:0] sram_rdata,
  output logic [3:0]  sram_be_n,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ack
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WR_SETUP, S_WR_PULSE,
    S_WR_HOLD, S_TX_WAIT, S_RX_WAIT, S_DONE
  } state_t;

  localparam logic [7:0] LAST = 8'(SRAM_WAIT - 1);

  state_t      r_state;
  state_t      w_nxt;
  logic        r_load;
  logic        r_byte;
  logic [21:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wd;
  logic [31:0] r_rdata;
  logic [7:0]  r_cnt;

  logic        w_req;
  logic        w_load;
  logic        w_byte;
  logic        w_is_data;
  logic        w_is_stat;
  logic        w_last;
  logic [7:0]  w_lane;
  logic        w_tx_valid;
  logic        w_rx_ack;

  assign w_load = (mem_mode == IO_LW) || (mem_mode == IO_LB);
  assign w_byte = (mem_mode == IO_LB) || (mem_mode == IO_SB);
  assign w_req  = (r_state == S_IDLE) &&
                  (w_load || w_byte || mem_mode == IO_SW);
  assign w_is_data = addr[31:2] == UART_DATA_ADDR[31:2];
  assign w_is_stat = addr[31:2] == UART_STAT_ADDR[31:2];
  assign w_last = r_cnt == LAST;
  assign w_lane = sram_rdata[{r_addr[1:0], 3'b000} +: 8];

  // State register; async reset also releases every strobe decoded below.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  // Next-state and UART handshake strobes.
  always_comb begin
    w_nxt      = r_state;
    w_tx_valid = 1'b0;
    w_rx_ack   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_req) begin
          unique case (1'b1)
            w_is_stat: w_nxt = S_DONE;
            w_is_data: w_nxt = w_load ? S_RX_WAIT : S_TX_WAIT;
            default:   w_nxt = w_load ? S_RD : S_WR_SETUP;
          endcase
        end
      end
      S_RD:       if (w_last) w_nxt = S_DONE;
      S_WR_SETUP: w_nxt = S_WR_PULSE;
      S_WR_PULSE: if (w_last) w_nxt = S_WR_HOLD;
      S_WR_HOLD:  w_nxt = S_DONE;
      S_TX_WAIT: begin
        if (uart_tx_ready) begin
          w_tx_valid = 1'b1;
          w_nxt      = S_DONE;
        end
      end
      S_RX_WAIT: begin
        if (uart_rx_valid) begin
          w_rx_ack = 1'b1;
          w_nxt    = S_DONE;
        end
      end
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // Request latch, wait counter and load-result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load  <= 1'b0;
      r_byte  <= 1'b0;
      r_addr  <= '0;
      r_be    <= 4'hF;
      r_wd    <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_req) begin
        r_load <= w_load;
        r_byte <= w_byte;
        r_addr <= addr[21:0];
        r_be   <= w_byte ? ~(4'b0001 << addr[1:0]) : 4'h0;
        r_wd   <= w_byte ? {4{wdata[7:0]}} : wdata;
        if (w_is_stat && w_load)
          r_rdata <= {30'b0, uart_rx_valid, uart_tx_ready};
      end
      if (r_state == S_RD || r_state == S_WR_PULSE)
        r_cnt <= r_cnt + 8'd1;
      else
        r_cnt <= '0;
      if (r_state == S_RD && w_last)
        r_rdata <= r_byte ? {{24{w_lane[7]}}, w_lane} : sram_rdata;
      if (w_rx_ack)
        r_rdata <= {{24{r_byte & uart_rx_data[7]}}, uart_rx_data};
    end
  end

  assign rdata         = r_rdata;
  assign busy          = r_state != S_IDLE;
  assign done          = r_state == S_DONE;
  assign sram_addr     = r_addr[21:2];
  assign sram_wdata    = r_wd;
  assign sram_drive    = r_state inside {S_WR_SETUP, S_WR_PULSE, S_WR_HOLD};
  assign sram_ce_n     = !(sram_drive || r_state == S_RD);
  assign sram_oe_n     = r_state != S_RD;
  assign sram_we_n     = r_state != S_WR_PULSE;
  assign sram_be_n     = (r_state == S_RD) ? 4'h0 :
                         sram_drive ? r_be : 4'hF;
  assign uart_tx_data  = r_wd[7:0];
  assign uart_tx_valid = w_tx_valid;
  assign uart_rx_ack   = w_rx_ack;

  logic w_unused;
  assign w_unused = r_load;

endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder: directed checks of SRAM and UART access sequences.
// Inputs change 1ns after rising edges; outputs sampled on falling edges.
module tb_mem_io_responder;
  import mem_io_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [3:0]  mem_mode;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic [19:0] sram_addr;
  logic [31:0] sram_wdata;
  logic        sram_drive;
  logic [31:0] sram_rdata;
  logic [3:0]  sram_be_n;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic        uart_rx_ack;

  mem_io_responder #(.SRAM_WAIT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_mode(mem_mode), .addr(addr), .wdata(wdata),
    .rdata(rdata), .busy(busy), .done(done),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_drive(sram_drive), .sram_rdata(sram_rdata),
    .sram_be_n(sram_be_n), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid),
    .uart_tx_ready(uart_tx_ready), .uart_rx_data(uart_rx_data),
    .uart_rx_valid(uart_rx_valid), .uart_rx_ack(uart_rx_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int          done_k, we_lo, oe_lo, drv_hi, viol;
  int          txv, rxa, busy_lo, post_bad;
  logic [19:0] s_addr;
  logic [3:0]  s_be;
  logic [31:0] s_wd;
  logic [7:0]  txd;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_uart(input int k, input int rdy_lo,
                            input int rxv_lo);
    uart_tx_ready = k > rdy_lo;
    uart_rx_valid = k > rxv_lo;
  endtask

  // Issue one request and record the response over a bounded window.
  task automatic watch(input logic [3:0] m, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] srd,
                       input logic [7:0] rxd, input int rdy_lo,
                       input int rxv_lo);
    done_k = 0; we_lo = 0; oe_lo = 0; drv_hi = 0; viol = 0;
    txv = 0; rxa = 0; busy_lo = 0; post_bad = 0;
    s_addr = '0; s_be = 4'hF; s_wd = '0; txd = '0;
    @(posedge clk); #1;
    mem_mode = m; addr = a; wdata = d;
    sram_rdata = srd; uart_rx_data = rxd;
    drive_uart(0, rdy_lo, rxv_lo);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      mem_mode = IO_NOP;
      drive_uart(k, rdy_lo, rxv_lo);
      @(negedge clk);
      if (!sram_we_n) we_lo++;
      if (!sram_oe_n) oe_lo++;
      if (sram_drive) drv_hi++;
      if ((!sram_we_n && sram_ce_n) || (sram_drive && !sram_oe_n))
        viol++;
      if (!sram_ce_n) begin
        s_addr = sram_addr; s_be = sram_be_n; s_wd = sram_wdata;
      end
      if (uart_tx_valid) begin txv++; txd = uart_tx_data; end
      if (uart_rx_ack) rxa++;
      if (!busy) busy_lo++;
      if (done) begin done_k = k; break; end
    end
    @(posedge clk); #1;
    @(negedge clk);
    post_bad = int'(done) + int'(busy) + int'(!sram_ce_n) +
               int'(uart_tx_valid) + int'(uart_rx_ack);
  endtask

  initial begin
    rst_n = 1'b0; mem_mode = IO_NOP; addr = '0; wdata = '0;
    sram_rdata = '0; uart_tx_ready = 1'b0; uart_rx_data = '0;
    uart_rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_busy_done", {busy, done}, 0);
    chk("rst_sram_ctl", {sram_ce_n, sram_oe_n, sram_we_n, sram_drive}, 4'hE);
    chk("rst_be_n", sram_be_n, 4'hF);
    chk("rst_sram_addr", sram_addr, 0);
    chk("rst_sram_wdata", sram_wdata, 0);
    chk("rst_uart", {uart_tx_data, uart_tx_valid, uart_rx_ack}, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    watch(IO_SW, 32'h80000104, 32'hDEADBEEF, 0, 0, 1000, 1000);
    chk("sw_done_k", done_k, 5);
    chk("sw_we_lo", we_lo, 2);
    chk("sw_drive_hi", drv_hi, 4);
    chk("sw_oe_lo", oe_lo, 0);
    chk("sw_viol", viol, 0);
    chk("sw_addr", s_addr, 20'h00041);
    chk("sw_be", s_be, 4'b0000);
    chk("sw_wd", s_wd, 32'hDEADBEEF);
    chk("sw_busy", busy_lo, 0);
    chk("sw_post", post_bad, 0);
    chk("sw_rdata", rdata, 32'h0);

    watch(IO_LW, 32'h80000104, 0, 32'h12345678, 0, 1000, 1000);
    chk("lw_done_k", done_k, 3);
    chk("lw_oe_lo", oe_lo, 2);
    chk("lw_we_drv", we_lo + drv_hi, 0);
    chk("lw_be", s_be, 4'b0000);
    chk("lw_rdata", rdata, 32'h12345678);
    chk("lw_post", post_bad, 0);

    watch(IO_LB, 32'h80000107, 0, 32'h80FFFFFF, 0, 1000, 1000);
    chk("lb_done_k", done_k, 3);
    chk("lb_rdata", rdata, 32'hFFFFFF80);

    watch(IO_SB, 32'h80000002, 32'h000000A5, 0, 0, 1000, 1000);
    chk("sb_done_k", done_k, 5);
    chk("sb_be", s_be, 4'b1011);
    chk("sb_wd", s_wd, 32'hA5A5A5A5);
    chk("sb_we_lo", we_lo, 2);
    chk("sb_rdata_kept", rdata, 32'hFFFFFF80);

    watch(IO_LW, 32'h80000002, 0, 32'hCAFEF00D, 0, 1000, 1000);
    chk("lw2_rdata", rdata, 32'hCAFEF00D);

    watch(IO_SB, 32'hBFD003F8, 32'h00000041, 0, 0, 3, 1000);
    chk("utx_done_k", done_k, 5);
    chk("utx_cnt", txv, 1);
    chk("utx_data", txd, 8'h41);
    chk("utx_busy", busy_lo, 0);
    chk("utx_sram_idle", drv_hi + oe_lo + we_lo, 0);
    chk("utx_post", post_bad, 0);
    chk("utx_rdata", rdata, 32'hCAFEF00D);

    watch(IO_LB, 32'hBFD003F8, 0, 0, 8'h9C, 1000, 4);
    chk("urx_done_k", done_k, 6);
    chk("urx_ack", rxa, 1);
    chk("urx_busy", busy_lo, 0);
    chk("urx_rdata", rdata, 32'hFFFFFF9C);

    watch(IO_LW, 32'hBFD003F8, 0, 0, 8'h9C, 1000, 0);
    chk("urxw_done_k", done_k, 2);
    chk("urxw_rdata", rdata, 32'h0000009C);

    watch(IO_LW, 32'hBFD003FC, 0, 0, 0, 1000, -1);
    chk("stat_done_k", done_k, 1);
    chk("stat_rdata", rdata, 32'h00000002);
    chk("stat_ack", rxa, 0);

    watch(IO_SW, 32'hBFD003FC, 32'hFFFFFFFF, 0, 0, -1, -1);
    chk("stst_done_k", done_k, 1);
    chk("stst_rdata", rdata, 32'h00000002);
    chk("stst_quiet", txv + rxa + drv_hi, 0);

    uart_rx_valid = 1'b0; uart_tx_ready = 1'b0;
    @(posedge clk); #1;
    mem_mode = IO_SW; addr = 32'h80000200; wdata = 32'h11223344;
    @(posedge clk); #1 mem_mode = IO_NOP;
    @(negedge clk);
    chk("rmid_setup", {sram_drive, sram_we_n, sram_ce_n}, 3'b110);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rmid_pulse", {sram_drive, sram_we_n, sram_ce_n}, 3'b100);
    #1 rst_n = 1'b0;
    #1;
    chk("rmid_async", {sram_drive, sram_we_n, sram_ce_n, sram_be_n}, 7'h3F);
    chk("rmid_busy_done", {busy, done}, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rmid_no_done", done, 0);
    end
    chk("rmid_rdata", rdata, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rmid_idle", {busy, done}, 0);

    watch(IO_LW, 32'h80000104, 0, 32'h0BADCAFE, 0, 1000, 1000);
    chk("post_lw_done_k", done_k, 3);
    chk("post_lw_rdata", rdata, 32'h0BADCAFE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
